// File: rtl/edge_writer_pkg.sv
// Shared types and widths for the edge-map writer: FSM states, address, pixel-index
// and byte sizes.
package edge_writer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush,
    StDone
  } state_e;

  localparam int unsigned AddrWidth  = 16;
  localparam int unsigned IdxWidth   = 8;
  localparam int unsigned ByteBits   = 8;
  localparam int unsigned EntryWidth = AddrWidth + ByteBits;

endpackage

// File: rtl/edge_fifo.sv
// Synchronous FIFO of {address, data} write entries. A push while full is accepted
// only when a pop happens in the same cycle.
module edge_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]    rd_ptr_q, rd_ptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q[PtrW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + {{PtrW{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_d = rd_ptr_q + {{PtrW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/edge_writer.sv
// Packs edge-decision bits LSB-first into bytes, checks pixel order against a raster
// counter, and streams the bytes to memory through a small FIFO.
module edge_writer
  import edge_writer_pkg::*;
#(
  parameter int unsigned COLS       = 254,
  parameter int unsigned ROWS       = 254,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Enable,
  input  logic                 PixValid,
  input  logic                 Dop,
  input  logic [IdxWidth-1:0]  Row,
  input  logic [IdxWidth-1:0]  Column,
  input  logic                 LastPix,
  output logic                 MemValid,
  input  logic                 MemReady,
  output logic [AddrWidth-1:0] MemAddr,
  output logic [ByteBits-1:0]  MemData,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Err
);

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [ByteBits-2:0]   bits_q, bits_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic [IdxWidth-1:0]   exp_row_q, exp_row_d;
  logic [IdxWidth-1:0]   exp_col_q, exp_col_d;
  logic                  err_q, err_d;

  logic                  accept, push_req, pop, drop;
  logic                  fifo_full, fifo_empty;
  logic [ByteBits-1:0]   byte_val;
  logic [EntryWidth-1:0] head;

  assign accept = PixValid && Enable && (state_q == StIdle || state_q == StRun);

  // Outputs are forced quiet while Reset is held so no stale request leaks out.
  assign MemValid = !fifo_empty && !Reset;
  assign pop      = MemValid && MemReady;
  assign drop     = push_req && fifo_full && !pop;
  assign MemAddr  = MemValid ? head[EntryWidth-1:ByteBits] : '0;
  assign MemData  = MemValid ? head[ByteBits-1:0] : '0;
  assign Busy     = !Reset && (state_q == StRun || state_q == StFlush);
  assign Done     = !Reset && (state_q == StDone);
  assign Err      = !Reset && err_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bits_d    = bits_q;
    addr_d    = addr_q;
    exp_row_d = exp_row_q;
    exp_col_d = exp_col_q;
    err_d     = err_q;
    push_req  = 1'b0;
    byte_val  = {1'b0, bits_q};

    if (accept) begin
      byte_val[cnt_q] = Dop;
      if (Row != exp_row_q || Column != exp_col_q) err_d = 1'b1;
      if (LastPix && !(exp_row_q == IdxWidth'(ROWS - 1) && exp_col_q == IdxWidth'(COLS - 1))) begin
        err_d = 1'b1;
      end

      if (exp_col_q == IdxWidth'(COLS - 1)) begin
        exp_col_d = '0;
        exp_row_d = (exp_row_q == IdxWidth'(ROWS - 1)) ? '0 : exp_row_q + 1'b1;
      end else begin
        exp_col_d = exp_col_q + 1'b1;
      end

      // Bits above the current count are always zero, so a short final byte is padded.
      if (cnt_q == 3'd7 || LastPix) begin
        push_req = 1'b1;
        cnt_d    = '0;
        bits_d   = '0;
      end else begin
        cnt_d  = cnt_q + 3'd1;
        bits_d = byte_val[ByteBits-2:0];
      end

      state_d = LastPix ? StFlush : StRun;
    end

    if (push_req) addr_d = addr_q + 1'b1;
    if (drop) err_d = 1'b1;

    if (state_q == StFlush && fifo_empty) state_d = StDone;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bits_q    <= '0;
      addr_q    <= '0;
      exp_row_q <= '0;
      exp_col_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bits_q    <= bits_d;
      addr_q    <= addr_d;
      exp_row_q <= exp_row_d;
      exp_col_q <= exp_col_d;
      err_q     <= err_d;
    end
  end

  edge_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (EntryWidth)
  ) u_fifo (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .push_i  (push_req),
    .wdata_i ({addr_q, byte_val}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_edge_writer.sv
// Directed bench for edge_writer: a vector table for the basic frame plus hand-written
// sequences for padding, back-pressure overflow, order errors, reset and enable gating.
module tb_edge_writer;

  logic        Clk = 1'b0;
  logic        Reset, Enable, PixValid, Dop, LastPix, MemReady;
  logic [7:0]  Row, Column;

  logic        a_valid, a_busy, a_done, a_err;
  logic [15:0] a_addr;
  logic [7:0]  a_data;
  logic        b_valid, b_busy, b_done, b_err;
  logic [15:0] b_addr;
  logic [7:0]  b_data;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  edge_writer #(.COLS(4), .ROWS(2), .FIFO_DEPTH(4)) u_dut_a (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .PixValid(PixValid), .Dop(Dop),
    .Row(Row), .Column(Column), .LastPix(LastPix), .MemValid(a_valid),
    .MemReady(MemReady), .MemAddr(a_addr), .MemData(a_data), .Busy(a_busy),
    .Done(a_done), .Err(a_err)
  );

  edge_writer #(.COLS(3), .ROWS(1), .FIFO_DEPTH(4)) u_dut_b (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .PixValid(PixValid), .Dop(Dop),
    .Row(Row), .Column(Column), .LastPix(LastPix), .MemValid(b_valid),
    .MemReady(MemReady), .MemAddr(b_addr), .MemData(b_data), .Busy(b_busy),
    .Done(b_done), .Err(b_err)
  );

  typedef struct {
    logic        pv;
    logic        dop;
    logic [7:0]  row;
    logic [7:0]  col;
    logic        last;
    logic        exp_valid;
    logic [15:0] exp_addr;
    logic [7:0]  exp_data;
    logic        exp_busy;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input logic pv, input logic dop, input int r, input int c,
                              input logic last, input logic ev, input int ea,
                              input logic [7:0] ed, input logic eb, input logic edn,
                              input logic ee);
    vec_t v;
    v.pv = pv; v.dop = dop; v.row = 8'(r); v.col = 8'(c); v.last = last;
    v.exp_valid = ev; v.exp_addr = 16'(ea); v.exp_data = ed;
    v.exp_busy = eb; v.exp_done = edn; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle;
    PixValid = 1'b0; Dop = 1'b0; LastPix = 1'b0; Row = '0; Column = '0;
  endtask

  task automatic do_reset;
    Reset = 1'b1;
    idle();
    tick();
    Reset = 1'b0;
  endtask

  task automatic pix(input logic d, input int r, input int c, input logic last);
    PixValid = 1'b1; Dop = d; Row = 8'(r); Column = 8'(c); LastPix = last;
    tick();
    idle();
  endtask

  // Eight pixels of a 4x2 frame, bit k of pat is the k-th pixel, LastPix on the 8th.
  task automatic frame8(input logic [7:0] pat);
    for (int k = 0; k < 8; k++) pix(pat[k], k / 4, k % 4, k == 7);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] pat;
    int         nw;
    logic       stable;
    int         addrs[$];

    pat = 8'h8D;
    for (int k = 0; k < 8; k++)
      vecs[k] = mk(1'b1, pat[k], k / 4, k % 4, k == 7, k == 7, 0, (k == 7) ? 8'h8D : 8'h00,
                   1'b1, 1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b0);
    vecs[9]  = mk(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0);
    vecs[10] = mk(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0);

    Enable = 1'b1; MemReady = 1'b1;
    Reset = 1'b1;
    idle();
    tick();
    chk("reset_during", {a_valid, a_addr, a_data, a_busy, a_done, a_err}, 32'h0);
    Reset = 1'b0;
    tick();
    chk("reset_after", {a_valid, a_addr, a_data, a_busy, a_done, a_err}, 32'h0);

    // 4x2 frame, pattern 1,0,1,1,0,0,0,1
    for (int i = 0; i < 11; i++) begin
      PixValid = vecs[i].pv; Dop = vecs[i].dop; Row = vecs[i].row;
      Column = vecs[i].col; LastPix = vecs[i].last;
      tick();
      chk($sformatf("vec%0d", i), {a_valid, a_addr, a_data, a_busy, a_done, a_err},
          {vecs[i].exp_valid, vecs[i].exp_addr, vecs[i].exp_data, vecs[i].exp_busy,
           vecs[i].exp_done, vecs[i].exp_err});
    end
    idle();

    // 3x1 frame, partial byte is zero-padded
    do_reset();
    pix(1'b1, 0, 0, 1'b0);
    pix(1'b1, 0, 1, 1'b0);
    pix(1'b1, 0, 2, 1'b1);
    chk("pad_req", {b_valid, b_addr, b_data}, {1'b1, 16'h0000, 8'h07});
    nw = 0;
    for (int k = 0; k < 20; k++) begin
      if (b_done) break;
      if (b_valid) nw++;
      tick();
    end
    chk("pad_writes", 32'(nw), 32'd1);
    chk("pad_done", {b_done, b_busy, b_err}, 3'b100);

    // Back-pressure: 5 bytes into a 4-deep FIFO
    do_reset();
    MemReady = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      pix(1'b1, (i / 4) % 2, i % 4, 1'b0);
      if (i == 31) chk("full_no_err", {a_valid, a_err}, 2'b10);
      if (i >= 31 && !(a_valid && a_addr == 16'h0 && a_data == 8'hFF)) stable = 1'b0;
    end
    chk("full_stable", 32'(stable), 32'd1);
    chk("overflow_err", 32'(a_err), 32'd1);
    MemReady = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (a_valid) addrs.push_back(int'(a_addr));
      tick();
    end
    chk("drain_count", 32'(addrs.size()), 32'd4);
    for (int j = 0; j < addrs.size() && j < 4; j++)
      chk($sformatf("drain_addr%0d", j), 32'(addrs[j]), 32'(j));

    // Out-of-order pixel sets Err, packing continues
    do_reset();
    pix(1'b1, 0, 0, 1'b0);
    chk("order_ok", 32'(a_err), 32'd0);
    pix(1'b1, 0, 2, 1'b0);
    chk("order_err", 32'(a_err), 32'd1);
    for (int k = 2; k < 8; k++) pix(1'b1, k / 4, k % 4, k == 7);
    chk("order_pack", {a_valid, a_addr, a_data}, {1'b1, 16'h0000, 8'hFF});

    // Reset mid-frame withdraws the pending request and clears Err
    do_reset();
    MemReady = 1'b0;
    pix(1'b1, 0, 1, 1'b0);
    for (int k = 1; k < 8; k++) pix(1'b1, k / 4, k % 4, 1'b0);
    for (int k = 0; k < 3; k++) pix(1'b0, 0, k, 1'b0);
    chk("mid_pre", {a_valid, a_busy, a_err}, 3'b111);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("mid_reset", {a_valid, a_busy, a_err}, 3'b000);
    MemReady = 1'b1;
    frame8(8'h8D);
    chk("mid_restart", {a_valid, a_addr, a_data, a_err}, {1'b1, 16'h0000, 8'h8D, 1'b0});

    // Enable low ignores pixels
    do_reset();
    Enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      PixValid = 1'b1; Dop = 1'b1; Row = 8'd3; Column = 8'd3;
      tick();
    end
    idle();
    chk("en_idle", {a_valid, a_busy, a_err}, 3'b000);
    Enable = 1'b1;
    frame8(8'h8D);
    chk("en_frame", {a_valid, a_addr, a_data, a_err}, {1'b1, 16'h0000, 8'h8D, 1'b0});
    for (int k = 0; k < 10; k++) begin
      if (a_done) break;
      tick();
    end
    chk("en_done", {a_done, a_busy, a_err}, 3'b100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_writer.md
EDGE_WRITER -- requirements
Module: edge_writer

Interface
REQ-001 Parameter COLS, default 254: pixels per output row, which is the column count of the Dop map.
REQ-002 Parameter ROWS, default 254: output rows per frame.
REQ-003 Parameter FIFO_DEPTH, default 4: number of packed-byte entries buffered toward memory (power of two).
REQ-004 Clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Enable  input  1  when 0, input pixels are ignored; memory handshake continues.
REQ-007 PixValid  input  1  one edge-decision pixel presented this cycle (driven by Loader isReady).
REQ-008 Dop  input  1  edge bit for the presented pixel.
REQ-009 Row  input  8  row index of the presented pixel.
REQ-010 Column  input  8  column index of the presented pixel.
REQ-011 LastPix  input  1  presented pixel is the final pixel of the frame (driven by Loader isEnd).
REQ-012 MemValid  output  1  write request valid.
REQ-013 MemReady  input  1  memory accepts the write when MemValid && MemReady.
REQ-014 MemAddr  output  16  byte address of the write.
REQ-015 MemData  output  8  packed edge bits.
REQ-016 Busy  output  1  asserted while in RUN or FLUSH.
REQ-017 Done  output  1  frame fully written.
REQ-018 Err  output  1  sticky error flag.

Function
REQ-019 States are IDLE, RUN, FLUSH, DONE; IDLE->RUN on the first accepted pixel.
REQ-020 A pixel is accepted iff PixValid && Enable && state is IDLE or RUN; pixels are ignored in FLUSH/DONE.
REQ-021 Packing is LSB-first: the k-th accepted pixel of a byte goes to bit k, with a 3-bit counter.
REQ-022 When the 8th bit is accepted, {Dop, 7 held bits} is pushed into the FIFO in that same cycle together with the byte address; the byte address counter then increments (wraps at 2^16).
REQ-023 Latency: a byte completed in cycle N appears on MemValid/MemData in cycle N+1 if the FIFO was empty.
REQ-024 MemValid = FIFO not empty; MemAddr/MemData show the head entry and remain stable while MemValid && !MemReady.
REQ-025 A push and a pop in the same cycle are both performed; this is legal even when the FIFO is full.
REQ-026 A push into a full FIFO with no simultaneous pop drops the byte, sets Err, and still advances the address.
REQ-027 Expected row/column counters start at (0,0) and advance column-first, wrapping at COLS then ROWS.
REQ-028 Each accepted pixel whose (Row,Column) differs from the expected position sets Err; the bit is still packed.
REQ-029 An accepted pixel with LastPix=1 moves the block to FLUSH. If the bit count after that pixel is nonzero, the partial byte is zero-padded in the upper bits and pushed that cycle.
REQ-030 LastPix accepted when the expected position is not (ROWS-1,COLS-1) sets Err.
REQ-031 FLUSH->DONE when the FIFO is empty and no pop is pending. In DONE, Done=1 and Busy=0, held until Reset.
REQ-032 Enable deasserting mid-frame freezes the packing state but not the memory drain.

Reset
REQ-033 Reset takes priority over all other inputs: state IDLE, bit/address/position counters 0, FIFO emptied.
REQ-034 Output values during and after reset: MemValid=0, MemAddr=0, MemData=0, Busy=0, Done=0, Err=0.
REQ-035 Reset asserted mid-frame discards buffered bytes; a request pending on MemValid is withdrawn the next cycle.

Structure
REQ-036 The shared package holds: the state enumeration, address width 16, pixel index width 8, and bits-per-byte 8.
REQ-037 The FIFO is a separate sub-module named edge_fifo (synchronous, parameterised depth and width 24 = addr+data); it exposes full/empty flags.
REQ-038 The packer, position checker and FSM reside in edge_writer.

Verification
REQ-039 Scenario: COLS=4, ROWS=2, MemReady=1, 8 pixels in order with Dop pattern 1,0,1,1,0,0,0,1 and LastPix on the 8th -> one write, Addr 0x0000, Data 0x8D, Done the cycle after the FIFO empties, Err=0.
REQ-040 Scenario: COLS=3, ROWS=1, Dop 1,1,1 with LastPix on the 3rd -> one write, Addr 0, Data 0x07 (zero-padded).
REQ-041 Scenario: MemReady held 0 with 40 pixels of all 1 and FIFO_DEPTH=4 -> 4 entries held stable, 5th byte dropped, Err=1. On release, addresses 0,1,2,3 are written.
REQ-042 Scenario: a pixel at (0,2) arrives where (0,1) is expected -> Err=1 the next cycle, and packing continues.
REQ-043 Scenario: Reset asserted for one cycle in the middle of a frame with MemValid=1 -> next cycle MemValid=0, Busy=0, Err=0. A new frame restarts at Addr 0.
REQ-044 Scenario: Enable=0 with PixValid=1 for 5 cycles -> no bits packed and position unchanged.
